// File: rtl/axi_read_arbiter.sv
// AR-channel scheduler for the 2-master / 5-slave read path: round-robin grant,
// address decode, AR routing and a local DECERR responder for decode misses.
module axi_read_arbiter #(
    parameter logic [31:0] S0_BASE = 32'h0000_0000,
    parameter logic [31:0] S0_MASK = 32'hFFFF_C000,
    parameter logic [31:0] S1_BASE = 32'h0001_0000,
    parameter logic [31:0] S1_MASK = 32'hFFFF_0000,
    parameter logic [31:0] S2_BASE = 32'h0002_0000,
    parameter logic [31:0] S2_MASK = 32'hFFFF_0000,
    parameter logic [31:0] S3_BASE = 32'h1000_0000,
    parameter logic [31:0] S3_MASK = 32'hFFFF_FC00,
    parameter logic [31:0] S4_BASE = 32'h2000_0000,
    parameter logic [31:0] S4_MASK = 32'hFFE0_0000
) (
    input  logic        ACLK,
    input  logic        ARESET,
    input  logic        ARVALID_M0,
    input  logic        ARVALID_M1,
    input  logic [31:0] ARADDR_M0,
    input  logic [31:0] ARADDR_M1,
    input  logic [3:0]  ARID_M0,
    input  logic [3:0]  ARID_M1,
    input  logic        ARREADY_S0,
    input  logic        ARREADY_S1,
    input  logic        ARREADY_S2,
    input  logic        ARREADY_S3,
    input  logic        ARREADY_S4,
    input  logic        RVALID_M0,
    input  logic        RREADY_M0,
    input  logic        RLAST_M0,
    input  logic        RVALID_M1,
    input  logic        RREADY_M1,
    input  logic        RLAST_M1,
    output logic        ARVALID_S0,
    output logic        ARVALID_S1,
    output logic        ARVALID_S2,
    output logic        ARVALID_S3,
    output logic        ARVALID_S4,
    output logic        ARREADY_M0,
    output logic        ARREADY_M1,
    output logic [3:0]  Arbiter_ARID_control,
    output logic [1:0]  Read_State_control,
    output logic        DEF_RVALID,
    output logic [7:0]  DEF_RID
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADDR = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;
    localparam logic [1:0] ST_DEFR = 2'd3;
    localparam logic [2:0] SLV_DEF = 3'd5;

    localparam logic [4:0][31:0] BASE_ARR = {S4_BASE, S3_BASE, S2_BASE, S1_BASE, S0_BASE};
    localparam logic [4:0][31:0] MASK_ARR = {S4_MASK, S3_MASK, S2_MASK, S1_MASK, S0_MASK};

    logic [1:0]  state_reg, state_next;
    logic        ptr_reg, ptr_next;
    logic        master_reg, master_next;
    logic [2:0]  slave_reg, slave_next;
    logic [3:0]  arid_reg, arid_next;

    logic        win_master;
    logic [31:0] win_addr;
    logic [4:0]  hit_vec;
    logic [2:0]  win_slave;
    logic [4:0]  slave_sel;
    logic [4:0]  arready_s;
    logic [4:0]  arvalid_s;
    logic        sel_arready;
    logic        g_arvalid, g_rready, g_rdone, g_arready;
    logic        addr_phase, is_default;

    // With both masters requesting the pointer decides; otherwise the lone requester wins.
    assign win_master = (ARVALID_M0 && ARVALID_M1) ? ptr_reg : ARVALID_M1;
    assign win_addr   = win_master ? ARADDR_M1 : ARADDR_M0;
    assign arready_s  = {ARREADY_S4, ARREADY_S3, ARREADY_S2, ARREADY_S1, ARREADY_S0};

    generate
        for (genvar gi = 0; gi < 5; gi++) begin : g_slave
            assign hit_vec[gi]   = (win_addr & MASK_ARR[gi]) == BASE_ARR[gi];
            assign slave_sel[gi] = (slave_reg == 3'(gi));
        end
    endgenerate

    // Lowest-numbered hit takes precedence over overlapping regions.
    always_comb begin
        win_slave = SLV_DEF;
        for (int i = 4; i >= 0; i--) begin
            if (hit_vec[i]) win_slave = 3'(i);
        end
    end

    assign g_arvalid  = master_reg ? ARVALID_M1 : ARVALID_M0;
    assign g_rready   = master_reg ? RREADY_M1 : RREADY_M0;
    assign g_rdone    = master_reg ? (RVALID_M1 && RREADY_M1 && RLAST_M1)
                                   : (RVALID_M0 && RREADY_M0 && RLAST_M0);
    assign addr_phase = (state_reg == ST_ADDR);
    assign is_default = (slave_reg == SLV_DEF);

    assign sel_arready = |(arready_s & slave_sel);
    assign arvalid_s   = slave_sel & {5{addr_phase && !is_default && g_arvalid}};
    assign g_arready   = addr_phase && (is_default || sel_arready);

    assign {ARVALID_S4, ARVALID_S3, ARVALID_S2, ARVALID_S1, ARVALID_S0} = arvalid_s;
    assign ARREADY_M0 = g_arready && !master_reg;
    assign ARREADY_M1 = g_arready && master_reg;

    always_comb begin
        state_next  = state_reg;
        ptr_next    = ptr_reg;
        master_next = master_reg;
        slave_next  = slave_reg;
        arid_next   = arid_reg;
        case (state_reg)
            ST_IDLE: begin
                if (ARVALID_M0 || ARVALID_M1) begin
                    state_next  = ST_ADDR;
                    master_next = win_master;
                    slave_next  = win_slave;
                    arid_next   = win_master ? ARID_M1 : ARID_M0;
                end
            end
            ST_ADDR: begin
                if (is_default)
                    state_next = ST_DEFR;
                else if (g_arvalid && sel_arready)
                    state_next = ST_DATA;
            end
            ST_DATA: begin
                if (g_rdone) begin
                    state_next = ST_IDLE;
                    ptr_next   = !master_reg;
                end
            end
            ST_DEFR: begin
                if (g_rready) begin
                    state_next = ST_IDLE;
                    ptr_next   = !master_reg;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_reg  <= ST_IDLE;
            ptr_reg    <= 1'b0;
            master_reg <= 1'b0;
            slave_reg  <= 3'd0;
            arid_reg   <= 4'd0;
        end else begin
            state_reg  <= state_next;
            ptr_reg    <= ptr_next;
            master_reg <= master_next;
            slave_reg  <= slave_next;
            arid_reg   <= arid_next;
        end
    end

    assign Arbiter_ARID_control = (state_reg == ST_IDLE) ? 4'hF : {master_reg, slave_reg};
    assign Read_State_control   = state_reg;
    assign DEF_RVALID           = (state_reg == ST_DEFR);
    assign DEF_RID              = {4'b0000, arid_reg};

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Scoreboard bench for axi_read_arbiter: expected grant codes are queued as
// requests are driven and checked when the arbiter enters its address phase.
module tb_axi_read_arbiter;

    logic        ACLK = 1'b0;
    logic        ARESET = 1'b1;
    logic [1:0]  arv_m = '0;
    logic [31:0] araddr_m [2];
    logic [3:0]  arid_m [2];
    logic [4:0]  arrs = '0;
    logic [1:0]  rv = '0, rr = '0, rl = '0;

    wire  [4:0]  arvs;
    logic        ARREADY_M0, ARREADY_M1;
    logic [3:0]  ctrl;
    logic [1:0]  rsc;
    logic        DEF_RVALID;
    logic [7:0]  DEF_RID;
    wire  [1:0]  arm = {ARREADY_M1, ARREADY_M0};

    int n_checks = 0;
    int n_errors = 0;
    logic [3:0] exp_q [$];

    always #5 ACLK = ~ACLK;

    axi_read_arbiter dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .ARVALID_M0(arv_m[0]), .ARVALID_M1(arv_m[1]),
        .ARADDR_M0(araddr_m[0]), .ARADDR_M1(araddr_m[1]),
        .ARID_M0(arid_m[0]), .ARID_M1(arid_m[1]),
        .ARREADY_S0(arrs[0]), .ARREADY_S1(arrs[1]), .ARREADY_S2(arrs[2]),
        .ARREADY_S3(arrs[3]), .ARREADY_S4(arrs[4]),
        .RVALID_M0(rv[0]), .RREADY_M0(rr[0]), .RLAST_M0(rl[0]),
        .RVALID_M1(rv[1]), .RREADY_M1(rr[1]), .RLAST_M1(rl[1]),
        .ARVALID_S0(arvs[0]), .ARVALID_S1(arvs[1]), .ARVALID_S2(arvs[2]),
        .ARVALID_S3(arvs[3]), .ARVALID_S4(arvs[4]),
        .ARREADY_M0(ARREADY_M0), .ARREADY_M1(ARREADY_M1),
        .Arbiter_ARID_control(ctrl), .Read_State_control(rsc),
        .DEF_RVALID(DEF_RVALID), .DEF_RID(DEF_RID)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Caller has just driven the request(s); returns early in the IDLE cycle after completion.
    task automatic serve(input int m, input int s, input int delay, input int beats, input bit toggle);
        logic [3:0] exp_ctrl;
        int o;
        o = 1 - m;
        @(negedge ACLK);
        #1;
        if (exp_q.size() > 0) exp_ctrl = exp_q.pop_front();
        else exp_ctrl = 4'hE;
        check("ctrl_addr", 32'(ctrl), 32'(exp_ctrl));
        check("state_addr", 32'(rsc), 1);
        check("other_arready", 32'(arm[o]), 0);
        if (s == 5) begin
            check("miss_arvalid_s", 32'(arvs), 0);
            check("miss_arready", 32'(arm[m]), 1);
            @(negedge ACLK);
            arv_m[m] = 1'b0;
            rr[m] = 1'b0;
            #1;
            check("defr_state", 32'(rsc), 3);
            check("defr_arready", 32'(arm), 0);
            check("defr_rid", 32'(DEF_RID), 32'(arid_m[m]));
            for (int c = 0; c < delay; c++) begin
                @(negedge ACLK);
                #1;
                check("def_rvalid_hold", 32'(DEF_RVALID), 1);
            end
            @(negedge ACLK);
            rr[m] = 1'b1;
            #1;
            check("def_rvalid_accept", 32'(DEF_RVALID), 1);
            @(negedge ACLK);
            rr[m] = 1'b0;
        end else begin
            for (int c = 0; c <= delay; c++) begin
                if (c > 0) @(negedge ACLK);
                arrs[s] = (c == delay);
                #1;
                check("arvalid_s", 32'(arvs), 32'(1) << s);
                check("arready_route", 32'(arm[m]), 32'(arrs[s]));
                check("other_arready_wait", 32'(arm[o]), 0);
            end
            @(negedge ACLK);
            arrs = '0;
            arv_m[m] = 1'b0;
            for (int b = 0; b < beats; b++) begin
                for (int p = (toggle ? 0 : 1); p < 2; p++) begin
                    rv[m] = 1'b1;
                    rl[m] = (b == beats - 1);
                    rr[m] = (p == 1);
                    #1;
                    check("data_state", 32'(rsc), 2);
                    check("data_ctrl", 32'(ctrl), 32'(exp_ctrl));
                    check("data_arvalid_s", 32'(arvs), 0);
                    @(negedge ACLK);
                end
            end
            rv[m] = 1'b0;
            rl[m] = 1'b0;
            rr[m] = 1'b0;
        end
        #1;
        check("idle_state", 32'(rsc), 0);
        check("idle_ctrl", 32'(ctrl), 32'hF);
        check("idle_def_rvalid", 32'(DEF_RVALID), 0);
        $display("txn master=%0d slave=%0d ctrl=%h beats=%0d", m, s, exp_ctrl, beats);
    endtask

    task automatic request(input int m, input logic [31:0] addr, input logic [3:0] id, input logic [3:0] exp_ctrl);
        arv_m[m] = 1'b1;
        araddr_m[m] = addr;
        arid_m[m] = id;
        exp_q.push_back(exp_ctrl);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        araddr_m[0] = '0; araddr_m[1] = '0;
        arid_m[0] = '0;   arid_m[1] = '0;
        repeat (3) @(negedge ACLK);
        #1;
        check("rst_ctrl", 32'(ctrl), 32'hF);
        check("rst_state", 32'(rsc), 0);
        check("rst_arvs", 32'(arvs), 0);
        check("rst_def", 32'({DEF_RVALID, DEF_RID}), 0);
        @(negedge ACLK);
        ARESET = 1'b0;

        // Contention from reset: M0 first, then M1 at the next IDLE.
        request(0, 32'h0000_0000, 4'd1, 4'h0);
        request(1, 32'h2000_0000, 4'd2, 4'hC);
        serve(0, 0, 0, 1, 1'b0);
        serve(1, 4, 1, 1, 1'b0);

        // Pointer back at M0 after M1 completed.
        request(0, 32'h0001_0000, 4'd4, 4'h1);
        request(1, 32'h1000_0000, 4'd6, 4'hB);
        serve(0, 1, 0, 1, 1'b0);
        serve(1, 3, 0, 2, 1'b0);

        // Single read to S2 with a two-cycle slave ARREADY delay.
        request(0, 32'h0002_0040, 4'd3, 4'h2);
        serve(0, 2, 2, 1, 1'b0);

        // Pointer moved to M1 even though M1 was idle: decode miss wins, then the S4 burst.
        request(0, 32'h2000_1000, 4'd8, 4'h4);
        request(1, 32'h3000_0000, 4'd5, 4'hD);
        exp_q.delete();
        exp_q.push_back(4'hD);
        exp_q.push_back(4'h4);
        serve(1, 5, 3, 0, 1'b0);
        serve(0, 4, 0, 4, 1'b1);

        // Reset in the middle of an M1 read from S3.
        @(negedge ACLK);
        request(1, 32'h1000_0004, 4'd7, 4'hB);
        @(negedge ACLK);
        arrs[3] = 1'b1;
        #1;
        check("rst_txn_ctrl", 32'(ctrl), 32'(exp_q.pop_front()));
        check("rst_txn_arvs", 32'(arvs), 32'h8);
        check("rst_txn_arready", 32'(ARREADY_M1), 1);
        @(negedge ACLK);
        arrs = '0;
        arv_m[1] = 1'b0;
        rv[1] = 1'b1;
        #1;
        check("rst_txn_data", 32'(rsc), 2);
        #2;
        ARESET = 1'b1;
        #1;
        check("midrst_ctrl", 32'(ctrl), 32'hF);
        check("midrst_state", 32'(rsc), 0);
        check("midrst_route", 32'({arvs, arm}), 0);
        check("midrst_def", 32'({DEF_RVALID, DEF_RID}), 0);
        @(negedge ACLK);
        ARESET = 1'b0;
        rv[1] = 1'b0;
        request(0, 32'h0002_0000, 4'd9, 4'h2);
        request(1, 32'h0001_0004, 4'd10, 4'h9);
        serve(0, 2, 0, 1, 1'b0);
        serve(1, 1, 1, 1, 1'b0);

        check("queue_empty", 32'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
